// File: rtl/ad9648_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad9648_cfg_pkg
// Description : Shared types and constants for the AD9648 configuration
//               sequencer: FSM state encoding, SPI command field positions,
//               register addresses and command-word builders.
// Revision    : 1.0  initial release
// ============================================================================
package ad9648_cfg_pkg;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ISSUE_WR = 4'd1,
    ST_WAIT_WR  = 4'd2,
    ST_ISSUE_RD = 4'd3,
    ST_WAIT_RD  = 4'd4,
    ST_CHECK    = 4'd5,
    ST_NEXT     = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8
  } state_e;

  // 24-bit command layout: [23]=R/nW, [22:21]=W1:W0, [20:8]=address, [7:0]=data.
  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 20;
  localparam int ADDR_LSB = 8;

  // Register addresses used by the default table.
  localparam logic [12:0] REG_TRANSFER   = 13'h0FF;
  localparam logic [12:0] REG_OUT_MODE   = 13'h014;
  localparam logic [12:0] REG_CLK_DIV    = 13'h00B;
  localparam logic [12:0] REG_PWR        = 13'h008;
  localparam logic [12:0] REG_TEST_MODE  = 13'h00D;
  localparam logic [12:0] REG_CLK_PHASE  = 13'h016;
  localparam logic [12:0] REG_DCO_DELAY  = 13'h017;
  localparam logic [12:0] REG_INPUT_SPAN = 13'h018;

  // Transfer-register commit: pushes shadowed settings into the active set.
  localparam logic [23:0] COMMIT = 24'h00FF01;

  // Single-byte write command.
  function automatic logic [23:0] mk_wr(input logic [12:0] addr, input logic [7:0] data);
    return {1'b0, 2'b00, addr, data};
  endfunction

  // Single-byte read command for the same address; data field is don't-care.
  function automatic logic [23:0] mk_rd(input logic [12:0] addr);
    return {1'b1, 2'b00, addr, 8'h00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad9648_cfg_rom.sv
`default_nettype none
// ============================================================================
// Module      : ad9648_cfg_rom
// Description : Combinational power-up command table for the AD9648.
//               The chip soft-reset (and its settling wait) is handled
//               elsewhere, so the table starts with functional settings and
//               always ends with the transfer-register commit.
// Ports       : index_i  table index
//               word_o   24-bit SPI command word for that index
// Revision    : 1.0  initial release
// ============================================================================
module ad9648_cfg_rom
  import ad9648_cfg_pkg::*;
#(
  parameter int NumEntries = 8
) (
  input  logic [$clog2(NumEntries)-1:0] index_i,
  output logic [23:0]                   word_o
);

  logic [31:0] idx;
  assign idx = 32'(index_i);

  always_comb begin
    word_o = COMMIT;
    // Any index at or beyond the final slot returns the commit word, so the
    // last entry is the commit regardless of table length.
    if (idx < 32'(NumEntries - 1)) begin
      case (idx)
        32'd0:   word_o = mk_wr(REG_OUT_MODE,   8'h01); // two's complement output
        32'd1:   word_o = mk_wr(REG_CLK_DIV,    8'h00); // clock divide by 1
        32'd2:   word_o = mk_wr(REG_PWR,        8'h00); // both channels normal power
        32'd3:   word_o = mk_wr(REG_CLK_PHASE,  8'h00); // no input clock phase adjust
        32'd4:   word_o = mk_wr(REG_DCO_DELAY,  8'h00); // no DCO delay
        32'd5:   word_o = mk_wr(REG_INPUT_SPAN, 8'h04); // input span selection
        32'd6:   word_o = mk_wr(REG_TEST_MODE,  8'h00); // test pattern off
        default: word_o = COMMIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad9648_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ad9648_cfg_sequencer
// Description : Walks the AD9648 command table, handing each word to the
//               config unit via a start/done handshake. Optionally reads
//               back each written register and retries on mismatch. Flags
//               completion or failure (mismatch exhaustion or timeout).
// Ports       : clk_sys_i, rst_sys_clk_i   clock, async active-high reset
//               start_i, verify_en_i       sequence start, readback enable
//               start_transfer_o,tx_data_o  command to config unit
//               transfer_done_i,rx_data_i   completion/readback from unit
//               busy_o, config_done_o       status
//               error_o, err_index_o,       failure flag, failing entry and
//               err_timeout_o               cause (1 = timeout)
// Revision    : 1.0  initial release
// ============================================================================
module ad9648_cfg_sequencer
  import ad9648_cfg_pkg::*;
#(
  parameter int TxRegWidth    = 24,
  parameter int RxRegWidth    = 8,
  parameter int NumEntries    = 8,
  parameter int MaxRetries    = 3,
  parameter int TimeoutCycles = 4096
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_sys_clk_i,
  input  logic                          start_i,
  input  logic                          verify_en_i,
  output logic                          start_transfer_o,
  output logic [TxRegWidth-1:0]         tx_data_o,
  input  logic                          transfer_done_i,
  input  logic [RxRegWidth-1:0]         rx_data_i,
  output logic                          busy_o,
  output logic                          config_done_o,
  output logic                          error_o,
  output logic [$clog2(NumEntries)-1:0] err_index_o,
  output logic                          err_timeout_o
);

  localparam int IdxW   = $clog2(NumEntries);
  localparam int RetryW = $clog2(MaxRetries + 1);
  localparam int TimerW = $clog2(TimeoutCycles);

  localparam logic [IdxW-1:0]   LAST_IDX    = IdxW'(NumEntries - 1);
  localparam logic [RetryW-1:0] RETRY_LIMIT = RetryW'(MaxRetries);
  localparam logic [TimerW-1:0] TIMER_LAST  = TimerW'(TimeoutCycles - 1);

  state_e                  state_q;
  logic [IdxW-1:0]         index_q;
  logic [RetryW-1:0]       retry_q;
  logic [TimerW-1:0]       timer_q;
  logic                    verify_q;
  logic [RxRegWidth-1:0]   rx_q;
  logic                    start_transfer_q;
  logic [TxRegWidth-1:0]   tx_data_q;
  logic                    busy_q;
  logic                    config_done_q;
  logic                    error_q;
  logic [IdxW-1:0]         err_index_q;
  logic                    err_timeout_q;

  // Incremented values, used where a counter advances.
  logic [IdxW-1:0]         index_d;
  logic [RetryW-1:0]       retry_d;
  logic [TimerW-1:0]       timer_d;

  logic [23:0]             rom_word;
  logic [23:0]             rd_cmd;
  logic                    is_last;
  logic                    verify_entry;
  logic                    rx_match;

  ad9648_cfg_rom #(
    .NumEntries (NumEntries)
  ) u_rom (
    .index_i (index_q),
    .word_o  (rom_word)
  );

  assign index_d = index_q + 1'b1;
  assign retry_d = retry_q + 1'b1;
  assign timer_d = timer_q + 1'b1;

  assign rd_cmd   = mk_rd(rom_word[ADDR_MSB:ADDR_LSB]);
  assign is_last  = (index_q == LAST_IDX);
  assign rx_match = (rx_q == rom_word[RxRegWidth-1:0]);

  // Read-type entries and the commit word are never read back: a read has
  // nothing to compare against, and the commit self-clears in the device.
  assign verify_entry = verify_q && !rom_word[RW_BIT] && !is_last;

  always_ff @(posedge clk_sys_i or posedge rst_sys_clk_i) begin
    if (rst_sys_clk_i) begin
      state_q          <= ST_IDLE;
      index_q          <= '0;
      retry_q          <= '0;
      timer_q          <= '0;
      verify_q         <= 1'b0;
      rx_q             <= '0;
      start_transfer_q <= 1'b0;
      tx_data_q        <= '0;
      busy_q           <= 1'b0;
      config_done_q    <= 1'b0;
      error_q          <= 1'b0;
      err_index_q      <= '0;
      err_timeout_q    <= 1'b0;
    end else begin
      start_transfer_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            config_done_q <= 1'b0;
            error_q       <= 1'b0;
            err_index_q   <= '0;
            err_timeout_q <= 1'b0;
            index_q       <= '0;
            retry_q       <= '0;
            verify_q      <= verify_en_i;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE_WR;
          end
        end

        ST_ISSUE_WR: begin
          tx_data_q        <= TxRegWidth'(rom_word);
          start_transfer_q <= 1'b1;
          timer_q          <= '0;
          state_q          <= ST_WAIT_WR;
        end

        ST_WAIT_WR: begin
          // Done takes priority over a simultaneous terminal count.
          if (transfer_done_i) begin
            state_q <= verify_entry ? ST_ISSUE_RD : ST_NEXT;
          end else if (timer_q == TIMER_LAST) begin
            error_q       <= 1'b1;
            err_index_q   <= index_q;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_ERR;
          end else begin
            timer_q <= timer_d;
          end
        end

        ST_ISSUE_RD: begin
          tx_data_q        <= TxRegWidth'(rd_cmd);
          start_transfer_q <= 1'b1;
          timer_q          <= '0;
          state_q          <= ST_WAIT_RD;
        end

        ST_WAIT_RD: begin
          if (transfer_done_i) begin
            rx_q    <= rx_data_i;
            state_q <= ST_CHECK;
          end else if (timer_q == TIMER_LAST) begin
            error_q       <= 1'b1;
            err_index_q   <= index_q;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_ERR;
          end else begin
            timer_q <= timer_d;
          end
        end

        ST_CHECK: begin
          if (rx_match) begin
            state_q <= ST_NEXT;
          end else if (retry_d < RETRY_LIMIT) begin
            retry_q <= retry_d;
            state_q <= ST_ISSUE_WR;
          end else begin
            error_q       <= 1'b1;
            err_index_q   <= index_q;
            err_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= ST_ERR;
          end
        end

        ST_NEXT: begin
          retry_q <= '0;
          if (is_last) begin
            config_done_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_DONE;
          end else begin
            index_q <= index_d;
            state_q <= ST_ISSUE_WR;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_transfer_o = start_transfer_q;
  assign tx_data_o        = tx_data_q;
  assign busy_o           = busy_q;
  assign config_done_o    = config_done_q;
  assign error_o          = error_q;
  assign err_index_o      = err_index_q;
  assign err_timeout_o    = err_timeout_q;

endmodule
`default_nettype wire
